// File: rtl/irq_ctrl_if.sv
// Trap handshake between the interrupt controller and the pipeline's trap logic.
// The controller raises a request with its mcause value; the pipeline answers
// with a single-cycle ack on trap entry and a single-cycle mret on return.
interface irq_ctrl_if;
    logic        irq_req;
    logic [31:0] irq_cause;
    logic        in_handler;
    logic        irq_ack;
    logic        mret;

    // Controller side
    modport master (
        output irq_req,
        output irq_cause,
        output in_handler,
        input  irq_ack,
        input  mret
    );

    // Pipeline side
    modport slave (
        input  irq_req,
        input  irq_cause,
        input  in_handler,
        output irq_ack,
        output mret
    );
endinterface

// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: samples the external, timer and software
// interrupt lines into mip, masks them with mie and mstatus.MIE, picks the
// highest-priority source (MEI > MSI > MTI) and runs a request / ack / mret
// handshake with the pipeline.
module irq_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ext_irq,
    input  logic              timer_irq,
    input  logic              sw_irq,
    input  logic [31:0]       mie,
    input  logic              mstatus_mie,
    irq_ctrl_if.master        trap,
    output logic [31:0]       mip
);

    localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
    localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
    localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HANDLER = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] ext_sync_reg;
    logic                   mtip_reg;
    logic                   msip_reg;
    logic                   meip;

    state_t                 state_reg, state_next;
    logic [31:0]            cause_reg, cause_next;

    logic                   ep_mei, ep_msi, ep_mti, ep_any;

    // ext_irq is asynchronous: pass it through a flop chain before use
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_sync_reg <= '0;
        end else begin
            ext_sync_reg <= {ext_sync_reg[SYNC_STAGES-2:0], ext_irq};
        end
    end

    // Timer and software lines are already synchronous; one register each
    always_ff @(posedge clk) begin
        if (rst) begin
            mtip_reg <= 1'b0;
            msip_reg <= 1'b0;
        end else begin
            mtip_reg <= timer_irq;
            msip_reg <= sw_irq;
        end
    end

    assign meip = ext_sync_reg[SYNC_STAGES-1];
    assign mip  = {20'b0, meip, 3'b0, mtip_reg, 3'b0, msip_reg, 3'b0};

    // Only the three machine-level bits of mie participate
    assign ep_mei = meip     & mie[11] & mstatus_mie;
    assign ep_mti = mtip_reg & mie[7]  & mstatus_mie;
    assign ep_msi = msip_reg & mie[3]  & mstatus_mie;
    assign ep_any = ep_mei | ep_msi | ep_mti;

    // State and latched cause registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cause_reg <= '0;
        end else begin
            state_reg <= state_next;
            cause_reg <= cause_next;
        end
    end

    // Next-state logic; the cause is frozen once a request is raised
    always_comb begin
        state_next = state_reg;
        cause_next = cause_reg;
        case (state_reg)
            IDLE: begin
                if (ep_any) begin
                    state_next = REQ;
                    if (ep_mei) begin
                        cause_next = CAUSE_MEI;
                    end else if (ep_msi) begin
                        cause_next = CAUSE_MSI;
                    end else begin
                        cause_next = CAUSE_MTI;
                    end
                end
            end
            REQ: begin
                // Ack takes precedence over a simultaneous withdraw
                if (trap.irq_ack) begin
                    state_next = HANDLER;
                end else if (!ep_any) begin
                    state_next = IDLE;
                end
            end
            HANDLER: begin
                if (trap.mret) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign trap.irq_req    = (state_reg == REQ);
    assign trap.in_handler = (state_reg == HANDLER);
    assign trap.irq_cause  = cause_reg;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: a table of directed vectors covering the handshake
// corner cases, followed by randomized traffic compared against a
// behavioural model of the controller.
module tb_irq_ctrl;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ext_irq = 1'b0;
    logic        timer_irq = 1'b0;
    logic        sw_irq = 1'b0;
    logic [31:0] mie = '0;
    logic        mstatus_mie = 1'b0;
    logic [31:0] mip;

    irq_ctrl_if trap_bus ();

    irq_ctrl #(.SYNC_STAGES(SYNC)) dut (
        .clk         (clk),
        .rst         (rst),
        .ext_irq     (ext_irq),
        .timer_irq   (timer_irq),
        .sw_irq      (sw_irq),
        .mie         (mie),
        .mstatus_mie (mstatus_mie),
        .trap        (trap_bus.master),
        .mip         (mip)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- behavioural model ----------------
    localparam int PH_IDLE = 0, PH_REQ = 1, PH_HND = 2;
    int          m_phase = PH_IDLE;
    logic [31:0] m_cause = '0;
    logic        m_mtip = 1'b0, m_msip = 1'b0;
    logic        ext_hist[$];   // most recent ext_irq sample at index 0

    function automatic logic m_meip();
        return ext_hist[SYNC-1];
    endfunction

    function automatic logic [31:0] m_mip();
        return (32'(m_meip()) << 11) | (32'(m_mtip) << 7) | (32'(m_msip) << 3);
    endfunction

    task automatic model_edge();
        logic e_mei, e_msi, e_mti;
        if (rst) begin
            m_phase = PH_IDLE;
            m_cause = '0;
            m_mtip  = 1'b0;
            m_msip  = 1'b0;
            ext_hist.delete();
            for (int i = 0; i < SYNC; i++) ext_hist.push_back(1'b0);
        end else begin
            e_mei = m_meip() && mie[11] && mstatus_mie;
            e_msi = m_msip   && mie[3]  && mstatus_mie;
            e_mti = m_mtip   && mie[7]  && mstatus_mie;
            if (m_phase == PH_IDLE) begin
                if (e_mei || e_msi || e_mti) begin
                    m_phase = PH_REQ;
                    m_cause = e_mei ? 32'h8000_000B : (e_msi ? 32'h8000_0003 : 32'h8000_0007);
                end
            end else if (m_phase == PH_REQ) begin
                if (trap_bus.irq_ack) m_phase = PH_HND;
                else if (!(e_mei || e_msi || e_mti)) m_phase = PH_IDLE;
            end else begin
                if (trap_bus.mret) m_phase = PH_IDLE;
            end
            m_mtip = timer_irq;
            m_msip = sw_irq;
            ext_hist.push_front(ext_irq);
            void'(ext_hist.pop_back());
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Drive one cycle of inputs, let the clock edge happen, advance the model
    task automatic apply(input logic r, input logic e, input logic t, input logic s,
                         input logic [31:0] m, input logic ms, input logic a, input logic mr);
        rst = r; ext_irq = e; timer_irq = t; sw_irq = s;
        mie = m; mstatus_mie = ms;
        trap_bus.irq_ack = a; trap_bus.mret = mr;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    typedef struct {
        logic        rst, ext, tmr, sw;
        logic [31:0] mie;
        logic        ms, ack, mret;
        logic        req, hnd;
        logic [31:0] cause, mip;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic r, input logic e, input logic t, input logic s,
                                input logic [31:0] m, input logic ms, input logic a, input logic mr,
                                input logic req, input logic hnd,
                                input logic [31:0] cause, input logic [31:0] mipv);
        vec_t v;
        v.rst = r; v.ext = e; v.tmr = t; v.sw = s; v.mie = m; v.ms = ms;
        v.ack = a; v.mret = mr; v.req = req; v.hnd = hnd; v.cause = cause; v.mip = mipv;
        vq.push_back(v);
    endfunction

    localparam logic [31:0] CB = 32'h8000_000B, C3 = 32'h8000_0003, C7 = 32'h8000_0007;
    localparam logic [31:0] M  = 32'h888;

    initial begin
        trap_bus.irq_ack = 1'b0;
        trap_bus.mret    = 1'b0;
        for (int i = 0; i < SYNC; i++) ext_hist.push_back(1'b0);

        //   rst ext tmr sw  mie   ms ack mret | req hnd cause  mip
        // reset and timer request / ack
        add(1, 0, 0, 0, 32'h0, 0, 0, 0,   0, 0, 32'h0, 32'h0);
        add(0, 0, 0, 0, M,     1, 0, 0,   0, 0, 32'h0, 32'h0);
        add(0, 0, 1, 0, M,     1, 0, 0,   0, 0, 32'h0, 32'h80);
        add(0, 0, 1, 0, M,     1, 0, 0,   1, 0, C7,    32'h80);
        add(0, 0, 1, 0, M,     1, 1, 0,   0, 1, C7,    32'h80);
        add(0, 0, 1, 0, M,     1, 1, 0,   0, 1, C7,    32'h80);   // stray ack in handler
        add(0, 0, 0, 0, M,     1, 0, 1,   0, 0, C7,    32'h0);
        add(0, 0, 0, 0, M,     1, 0, 0,   0, 0, C7,    32'h0);
        // all three rise together: MSI wins before MEI is synchronized
        add(0, 1, 1, 1, M,     1, 0, 0,   0, 0, C7,    32'h88);
        add(0, 1, 1, 1, M,     1, 0, 0,   1, 0, C3,    32'h888);
        add(0, 1, 1, 1, M,     1, 0, 0,   1, 0, C3,    32'h888);  // cause frozen
        add(0, 1, 1, 1, M,     1, 1, 0,   0, 1, C3,    32'h888);
        add(0, 1, 1, 1, M,     1, 0, 1,   0, 0, C3,    32'h888);
        add(0, 1, 1, 1, M,     1, 0, 0,   1, 0, CB,    32'h888);  // re-request as MEI
        add(0, 1, 1, 1, M,     1, 1, 0,   0, 1, CB,    32'h888);
        add(0, 0, 0, 0, M,     0, 0, 1,   0, 0, CB,    32'h800);
        add(0, 0, 0, 0, M,     0, 0, 0,   0, 0, CB,    32'h0);
        // withdraw by clearing mie[3]
        add(0, 0, 0, 1, M,     1, 0, 0,   0, 0, CB,    32'h8);
        add(0, 0, 0, 1, M,     1, 0, 0,   1, 0, C3,    32'h8);
        add(0, 0, 0, 1, 32'h880, 1, 0, 0, 0, 0, C3,    32'h8);
        add(0, 0, 0, 1, 32'h880, 1, 0, 0, 0, 0, C3,    32'h8);
        // ack together with source drop: ack wins
        add(0, 0, 0, 1, M,     1, 0, 0,   1, 0, C3,    32'h8);
        add(0, 0, 0, 0, M,     1, 1, 0,   0, 1, C3,    32'h0);
        add(0, 0, 0, 0, M,     1, 0, 1,   0, 0, C3,    32'h0);
        // global enable gates everything
        add(0, 1, 1, 1, M,     0, 0, 0,   0, 0, C3,    32'h88);
        add(0, 1, 1, 1, M,     0, 0, 0,   0, 0, C3,    32'h888);
        add(0, 1, 1, 1, M,     1, 0, 0,   1, 0, CB,    32'h888);
        // reset from handler, then ignored mret / ack in idle
        add(0, 1, 1, 1, M,     1, 1, 0,   0, 1, CB,    32'h888);
        add(1, 1, 1, 1, M,     1, 0, 0,   0, 0, 32'h0, 32'h0);
        add(0, 0, 0, 0, M,     1, 0, 1,   0, 0, 32'h0, 32'h0);
        add(0, 0, 0, 0, M,     1, 1, 0,   0, 0, 32'h0, 32'h0);
        // mret ignored in REQ; ack+mret in REQ -> handler
        add(0, 0, 0, 1, M,     1, 0, 0,   0, 0, 32'h0, 32'h8);
        add(0, 0, 0, 1, M,     1, 0, 0,   1, 0, C3,    32'h8);
        add(0, 0, 0, 1, M,     1, 0, 1,   1, 0, C3,    32'h8);
        add(0, 0, 0, 1, M,     1, 1, 1,   0, 1, C3,    32'h8);
        add(0, 0, 0, 0, M,     1, 0, 1,   0, 0, C3,    32'h0);
        // unrelated mie bits do not enable anything
        add(0, 0, 1, 1, 32'hFFFF_F777, 1, 0, 0, 0, 0, C3, 32'h88);
        add(0, 0, 1, 1, 32'hFFFF_F777, 1, 0, 0, 0, 0, C3, 32'h88);

        foreach (vq[i]) begin
            apply(vq[i].rst, vq[i].ext, vq[i].tmr, vq[i].sw, vq[i].mie,
                  vq[i].ms, vq[i].ack, vq[i].mret);
            check($sformatf("vec%0d irq_req", i),    32'(trap_bus.irq_req),    32'(vq[i].req));
            check($sformatf("vec%0d in_handler", i), 32'(trap_bus.in_handler), 32'(vq[i].hnd));
            check($sformatf("vec%0d irq_cause", i),  trap_bus.irq_cause,       vq[i].cause);
            check($sformatf("vec%0d mip", i),        mip,                      vq[i].mip);
            $display("vec%0d: req=%0b hnd=%0b cause=0x%08h mip=0x%03h", i,
                     trap_bus.irq_req, trap_bus.in_handler, trap_bus.irq_cause, mip);
        end

        // randomized traffic against the model
        begin
            logic e = 1'b0, t = 1'b0, s = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                logic [31:0] m;
                if ($urandom_range(7) == 0) e = ~e;
                if ($urandom_range(7) == 0) t = ~t;
                if ($urandom_range(7) == 0) s = ~s;
                m = $urandom;
                m[11] = ($urandom_range(3) != 0);
                m[7]  = ($urandom_range(3) != 0);
                m[3]  = ($urandom_range(3) != 0);
                apply($urandom_range(199) == 0, e, t, s, m, $urandom_range(7) != 0,
                      $urandom_range(3) == 0, $urandom_range(3) == 0);
                check($sformatf("rnd%0d irq_req", c),    32'(trap_bus.irq_req),    32'(m_phase == PH_REQ));
                check($sformatf("rnd%0d in_handler", c), 32'(trap_bus.in_handler), 32'(m_phase == PH_HND));
                check($sformatf("rnd%0d irq_cause", c),  trap_bus.irq_cause,       m_cause);
                check($sformatf("rnd%0d mip", c),        mip,                      m_mip());
                if (c % 250 == 0)
                    $display("rnd%0d: req=%0b hnd=%0b cause=0x%08h mip=0x%03h", c,
                             trap_bus.irq_req, trap_bus.in_handler, trap_bus.irq_cause, mip);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Machine-mode interrupt controller for the RV32I core. Samples the external, timer and software interrupt lines and presents them as the readable `mip` CSR value. Combines pending bits with the `mie` register value and `mstatus.MIE`, selects the highest-priority interrupt, and runs a request/acknowledge handshake with the pipeline's trap logic through trap entry and `mret`. It is the consumer of the `mie` CSR: the CSR file writes `mie`, and this block reads it.

## Interface
- `SYNC_STAGES`, default 2: flop count of the synchronizer on `ext_irq`; legal values are 2 or more.
- `clk`  in  1  core clock.
- `rst`  in  1  reset, synchronous, active-high.
- `ext_irq`  in  1  external interrupt, level-high, asynchronous to `clk`.
- `timer_irq`  in  1  timer interrupt (mtime >= mtimecmp), level-high, synchronous.
- `sw_irq`  in  1  software interrupt (msip register bit), level-high, synchronous.
- `mie`  in  32  current `mie` CSR value; only bits 11, 7 and 3 are used.
- `mstatus_mie`  in  1  global machine interrupt enable.
- `irq_ack`  in  1  pipeline took the trap at an instruction boundary (single-cycle pulse).
- `mret`  in  1  pipeline retired `mret` (single-cycle pulse).
- `irq_req`  out  1  trap request to the pipeline.
- `irq_cause`  out  32  `mcause` value for the request.
- `mip`  out  32  readable `mip`: {20'b0, meip, 3'b0, mtip, 3'b0, msip, 3'b0}.
- `in_handler`  out  1  high while an interrupt handler is active.

## Operation
- Pending bits:
  - `meip` is the last stage of the `SYNC_STAGES`-flop chain on `ext_irq`.
  - `mtip` and `msip` are single registers sampling `timer_irq` and `sw_irq` every cycle.
  - All three are level-following; no latching or clearing happens here.
- Enabled-pending is `mip & mie & {32{mstatus_mie}}`, restricted to bits 11, 7 and 3. All other `mie` bits are ignored.
- Priority is MEI > MSI > MTI. Cause codes:
  - MEI: 32'h8000_000B
  - MSI: 32'h8000_0003
  - MTI: 32'h8000_0007
- FSM states are IDLE, REQ and HANDLER.
  - IDLE: if any enabled-pending bit is set, latch the cause of the winner into `irq_cause` and go to REQ. `irq_req` = 0.
  - REQ: `irq_req` = 1 and `irq_cause` stays frozen. A higher-priority arrival does not change the cause.
    - If `irq_ack`, go to HANDLER.
    - Else, if enabled-pending is now all zero (source dropped, `mie` bit cleared, or `mstatus_mie` cleared), withdraw and go to IDLE.
    - Otherwise stay in REQ.
  - HANDLER: `irq_req` = 0, `in_handler` = 1, `irq_cause` holds. On `mret`, go to IDLE.
- Simultaneous events:
  - `irq_ack` and a withdraw condition in the same cycle: ack wins, go to HANDLER.
  - `irq_ack` and `mret` in the same cycle in REQ: ack wins.
- Ignored inputs:
  - `irq_ack` outside REQ is ignored.
  - `mret` outside HANDLER is ignored.
- On return to IDLE, a still-enabled-pending interrupt re-requests through the normal IDLE→REQ path.

## Timing
- Reset values (the `rst` edge clears everything):
  - `irq_req` = 0, `irq_cause` = 0, `mip` = 0, `in_handler` = 0.
  - FSM = IDLE; synchronizer chain = 0.
- `rst` asserted mid-operation (REQ or HANDLER): at the next edge the block is in IDLE with all outputs 0.
- `timer_irq`/`sw_irq` first sampled high at edge t: the `mip` bit is 1 after t; `irq_req` is 1 after t+1 (if enabled and in IDLE).
- `ext_irq` first sampled high at edge t: `meip` is 1 after edge t+SYNC_STAGES-1; `irq_req` follows one edge later.
- `mie` or `mstatus_mie` changes take effect in the FSM decision at the next edge (no extra latency).
- `irq_ack` sampled at edge t in REQ: `irq_req` = 0 and `in_handler` = 1 after t.
- `mret` sampled at edge t in HANDLER: IDLE after t. If the interrupt is still enabled-pending, `irq_req` is 1 again after t+1.
- Withdraw sampled at edge t: `irq_req` = 0 after t.

## Test plan
- Reset, then `mie`=0x888, `mstatus_mie`=1, and `timer_irq` 0→1 sampled at edge t → `mip`=0x80 after t; `irq_req`=1 and `irq_cause`=0x80000007 after t+1. Pulse `irq_ack` → `irq_req`=0 and `in_handler`=1 next cycle.
- `ext_irq`, `sw_irq` and `timer_irq` all rise in the same cycle, with `mie`=0x888 and SYNC_STAGES=2 → the first request has cause 0x80000003 (MSI arrives before the synchronized MEI). The cause stays frozen while `meip` rises. Ack then `mret` → re-request with 0x8000000B.
- In REQ for `sw_irq`, clear `mie[3]` with no ack → `irq_req` drops after one edge; FSM is IDLE; `mip` still shows 0x8.
- In REQ, assert `irq_ack` and drop `sw_irq` in the same cycle → HANDLER entered, `in_handler`=1, and `irq_cause` stays 0x80000003.
- `mstatus_mie`=0 with all sources high and `mie`=0x888 → `mip`=0x888 and `irq_req` stays 0. Set `mstatus_mie`=1 → `irq_req`=1 with 0x8000000B one edge later.
- Assert `rst` for one cycle while in HANDLER → all outputs 0 and IDLE after the edge. `mret` while IDLE has no effect. Stray `irq_ack` in HANDLER has no effect.
